bcd_to_serial_8_bit: RTL and testbench

Transmit-side counterpart of the 8-bit serial-binary-to-BCD receiver. It accepts a 3-digit BCD value (000..255) as a 10-bit parallel word and converts it to 8-bit binary over a fixed number of cycles. It then shifts the binary result out MSB first, one bit per clock. The serial output uses the same framing as the receiver's input, so the two blocks can run back to back in loopback tests.

---
 rtl/bcd_to_serial_8_bit.sv | 111 +++++++++++
 tb/tb_bcd_to_serial_8_bit.sv | 106 ++++++++++
 2 files changed

// File: rtl/bcd_to_serial_8_bit.sv
// bcd_to_serial_8_bit: 3-digit BCD word to binary, then shifted out serially MSB first
// Ports:
//   clk, rst_n (async, active-high reset)
//   start_i, dec_input_i : request and BCD value (hundreds[9:8], tens[7:4], units[3:0])
//   busy_o               : frame in progress
//   bit_valid_o, bin_output_o : serial payload bit and its qualifier
//   done_o, err_o        : one-cycle end-of-frame / rejected-request pulses
module bcd_to_serial_8_bit #(
    parameter int DATA_W = 8,
    parameter int BCD_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [BCD_W-1:0] dec_input_i,
    output logic             busy_o,
    output logic             bit_valid_o,
    output logic             bin_output_o,
    output logic             done_o,
    output logic             err_o
);
    localparam int W = 12 + DATA_W;
    typedef enum logic [1:0] {IDLE, CONVERT, SHIFT} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [W-1:0] work, work_n, sh, step;
    logic [DATA_W-1:0] sreg, sreg_n;
    logic busy_n, valid_n, bout_n, done_n, err_n;
    logic [9:0] value;
    logic ok;
    function automatic logic [3:0] adj(input logic [3:0] d);
        return d >= 4'd8 ? d - 4'd3 : d;
    endfunction
    // reverse double-dabble: shift right, then pull every digit >=8 back by 3
    assign sh = work >> 1;
    assign step = {adj(sh[W-1:W-4]), adj(sh[W-5:W-8]), adj(sh[W-9:W-12]), sh[DATA_W-1:0]};
    assign value = 10'(dec_input_i[9:8]) * 10'd100 + 10'(dec_input_i[7:4]) * 10'd10 + 10'(dec_input_i[3:0]);
    assign ok = dec_input_i[9:8] <= 2'd2 && dec_input_i[7:4] <= 4'd9 && dec_input_i[3:0] <= 4'd9 && value <= 10'd255;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        work_n = work;
        sreg_n = sreg;
        busy_n = busy_o;
        valid_n = 1'b0;
        bout_n = 1'b0;
        done_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                cnt_n = '0;
                if (start_i && ok) begin
                    work_n = {2'b00, dec_input_i, {DATA_W{1'b0}}};
                    state_n = CONVERT;
                    busy_n = 1'b1;
                end
                err_n = start_i && !ok;
            end
            CONVERT: begin
                work_n = step;
                cnt_n = cnt + 4'd1;
                // last conversion step feeds the first payload bit directly
                if (cnt == 4'(DATA_W - 1)) begin
                    sreg_n = step[DATA_W-1:0] << 1;
                    bout_n = step[DATA_W-1];
                    valid_n = 1'b1;
                    cnt_n = 4'd1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 4'(DATA_W)) begin
                    state_n = IDLE;
                    busy_n = 1'b0;
                    done_n = 1'b1;
                    cnt_n = '0;
                end else begin
                    valid_n = 1'b1;
                    bout_n = sreg[DATA_W-1];
                    sreg_n = sreg << 1;
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
            cnt <= '0;
            work <= '0;
            sreg <= '0;
            busy_o <= 1'b0;
            bit_valid_o <= 1'b0;
            bin_output_o <= 1'b0;
            done_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            work <= work_n;
            sreg <= sreg_n;
            busy_o <= busy_n;
            bit_valid_o <= valid_n;
            bin_output_o <= bout_n;
            done_o <= done_n;
            err_o <= err_n;
        end
    end
endmodule

// File: tb/tb_bcd_to_serial_8_bit.sv
// tb_bcd_to_serial_8_bit: randomized self-checking bench against a decimal-arithmetic reference
module tb_bcd_to_serial_8_bit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_i = 1'b0;
    logic [9:0] dec_input_i = '0;
    logic busy_o, bit_valid_o, bin_output_o, done_o, err_o;
    logic [4:0] o;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    bcd_to_serial_8_bit dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .dec_input_i(dec_input_i),
        .busy_o(busy_o),
        .bit_valid_o(bit_valid_o),
        .bin_output_o(bin_output_o),
        .done_o(done_o),
        .err_o(err_o)
    );
    assign o = {busy_o, bit_valid_o, bin_output_o, done_o, err_o};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic int bcd_val(input logic [9:0] d);
        return int'(d[9:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction
    function automatic bit bcd_ok(input logic [9:0] d);
        return d[9:8] <= 2 && d[7:4] <= 9 && d[3:0] <= 9 && bcd_val(d) <= 255;
    endfunction
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle", 32'(o), 32'd0);
        end
    endtask
    task automatic run(input logic [9:0] d, input bit hold, input logic [9:0] d_after, input bit chain, input int abort_at);
        bit ok;
        logic [7:0] bv;
        logic [4:0] e;
        logic b;
        ok = bcd_ok(d);
        bv = 8'(bcd_val(d));
        if (!chain) @(negedge clk);
        start_i = 1'b1;
        dec_input_i = d;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            b = 1'b0;
            if (k >= 8 && k < 16) b = bv[15-k];
            if (ok) e = {k < 16, k >= 8 && k < 16, b, k == 16, 1'b0};
            else e = {4'b0000, k == 0};
            chk($sformatf("d=%03h k=%0d", d, k), 32'(o), 32'(e));
            if (!hold) start_i = 1'b0;
            dec_input_i = d_after;
            if (k == abort_at) begin
                start_i = 1'b0;
                rst_n = 1'b1;
                #1 chk("abort", 32'(o), 32'd0);
                @(negedge clk);
                chk("abort_hold", 32'(o), 32'd0);
                rst_n = 1'b0;
                return;
            end
            if (!ok && k == 3) return;
        end
    endtask
    initial begin
        int v;
        logic [9:0] d;
        repeat (2) @(negedge clk);
        chk("reset", 32'(o), 32'd0);
        rst_n = 1'b0;
        idle(2);
        run(10'h214, 1'b0, 10'h214, 1'b0, -1);
        run(10'h000, 1'b0, 10'h000, 1'b0, -1);
        run(10'h255, 1'b0, 10'h255, 1'b0, -1);
        run(10'h256, 1'b0, 10'h256, 1'b0, -1);
        run(10'h30A, 1'b0, 10'h30A, 1'b0, -1);
        run(10'h0A0, 1'b0, 10'h0A0, 1'b0, -1);
        run(10'h128, 1'b1, 10'h128, 1'b0, -1);
        run(10'h128, 1'b0, 10'h128, 1'b1, -1);
        run(10'h214, 1'b0, 10'h214, 1'b0, 11);
        idle(1);
        run(10'h099, 1'b0, 10'h099, 1'b0, -1);
        run(10'h200, 1'b0, 10'h111, 1'b0, -1);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                v = int'($urandom_range(0, 255));
                d = 10'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
            end else begin
                d = 10'($urandom);
            end
            run(d, 1'b0, 10'($urandom), 1'b0, -1);
            idle(int'($urandom_range(0, 3)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
